// File: rtl/regfile_sb_if.sv
// -----------------------------------------------------------------------------
// regfile_sb_if
// Bus interface for the scoreboarded register file regfile_sb.
//
// Parameters:
//   XLEN  - register data width in bits
//   NREGS - register count (power of two, 2..64); AW = log2(NREGS)
//
// Signals:
//   rs1_addr, rs2_addr  - read addresses                 (master -> slave)
//   rs1_data, rs2_data  - combinational read data        (slave  -> master)
//   rs1_busy, rs2_busy  - pending-write flag of the read address (slave -> master)
//   we0/wa0/wd0         - write port 0 enable/address/data  (master -> slave)
//   we1/wa1/wd1         - write port 1 enable/address/data  (master -> slave)
//   issue_en, issue_rd  - mark issue_rd as pending write     (master -> slave)
//   busy_vec            - registered scoreboard, bit i = register i (slave -> master)
//
// Modports: master (drives requests), slave (the register file).
// -----------------------------------------------------------------------------
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            we0;
  logic            we1;
  logic [AW-1:0]   wa0;
  logic [AW-1:0]   wa1;
  logic [XLEN-1:0] wd0;
  logic [XLEN-1:0] wd1;
  logic            issue_en;
  logic [AW-1:0]   issue_rd;
  logic [NREGS-1:0] busy_vec;

  modport master (
    output rs1_addr, rs2_addr, we0, we1, wa0, wa1, wd0, wd1, issue_en, issue_rd,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, busy_vec
  );

  modport slave (
    input  rs1_addr, rs2_addr, we0, we1, wa0, wa1, wd0, wd1, issue_en, issue_rd,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, busy_vec
  );
endinterface

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Two-read / two-write register file with a per-register pending-write
// scoreboard. Register 0 is hard-wired to zero and can never be marked busy.
//
// Ports:
//   clk   - single clock, all state updates on the rising edge
//   reset - synchronous active-high reset (clears registers and busy bits,
//           ignores all write/issue inputs in that cycle)
//   bus   - regfile_sb_if.slave: read ports, two write ports, issue port,
//           registered busy_vec
//
// Write port 1 wins over write port 0 on the same address. On the same
// register, an issue (set) wins over a writeback (clear).
//
// Optional feature (macro REGFILE_BYPASS_EN): a read of a non-zero address
// being written in the same cycle returns the write data (port 1 first) and
// reports not-busy. Without the macro, reads return stored state only.
// -----------------------------------------------------------------------------
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic          clk,
  input logic          reset,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [XLEN:0]    rs1_rd;
  logic [XLEN:0]    rs2_rd;

`ifdef REGFILE_BYPASS_EN
  // Forward same-cycle write data onto a read; port 1 is checked first so it
  // has priority, matching the write ordering of the register update.
  function automatic logic [XLEN:0] bypass(
    input logic [AW-1:0]   addr,
    input logic [XLEN:0]   stored,
    input logic            we0,
    input logic [AW-1:0]   wa0,
    input logic [XLEN-1:0] wd0,
    input logic            we1,
    input logic [AW-1:0]   wa1,
    input logic [XLEN-1:0] wd1
  );
    logic [XLEN:0] r;
    r = stored;
    if (we1 && (wa1 == addr)) begin
      r = {1'b0, wd1};
    end else if (we0 && (wa0 == addr)) begin
      r = {1'b0, wd0};
    end else begin
      r = stored;
    end
    return r;
  endfunction
`endif

  // Next-state for registers and scoreboard bits.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    // Port 0 first, port 1 second: port 1 overwrites on an address clash.
    if (bus.we0) begin
      regs_d[bus.wa0] = bus.wd0;
      busy_d[bus.wa0] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (bus.we1) begin
      regs_d[bus.wa1] = bus.wd1;
      busy_d[bus.wa1] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    // Issue is applied after the writeback clears so set wins.
    if (bus.issue_en) begin
      busy_d[bus.issue_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    // Register 0 is constant zero and never pending.
    regs_d[0] = {XLEN{1'b0}};
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {XLEN{1'b0}};
      end
      busy_q <= {NREGS{1'b0}};
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read port 1: {busy, data}.
  always_comb begin
    rs1_rd = {busy_q[bus.rs1_addr], regs_q[bus.rs1_addr]};
`ifdef REGFILE_BYPASS_EN
    rs1_rd = bypass(bus.rs1_addr, rs1_rd, bus.we0, bus.wa0, bus.wd0,
                    bus.we1, bus.wa1, bus.wd1);
`endif
    // Address 0 reads as zero/not-busy regardless of stored contents.
    if (bus.rs1_addr == {AW{1'b0}}) begin
      rs1_rd = {(XLEN+1){1'b0}};
    end else begin
      rs1_rd = rs1_rd;
    end
  end

  // Read port 2: {busy, data}.
  always_comb begin
    rs2_rd = {busy_q[bus.rs2_addr], regs_q[bus.rs2_addr]};
`ifdef REGFILE_BYPASS_EN
    rs2_rd = bypass(bus.rs2_addr, rs2_rd, bus.we0, bus.wa0, bus.wd0,
                    bus.we1, bus.wa1, bus.wd1);
`endif
    if (bus.rs2_addr == {AW{1'b0}}) begin
      rs2_rd = {(XLEN+1){1'b0}};
    end else begin
      rs2_rd = rs2_rd;
    end
  end

  assign bus.rs1_data = rs1_rd[XLEN-1:0];
  assign bus.rs1_busy = rs1_rd[XLEN];
  assign bus.rs2_data = rs2_rd[XLEN-1:0];
  assign bus.rs2_busy = rs2_rd[XLEN];
  assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
// Self-checking bench for regfile_sb (XLEN=32, NREGS=32). A vector table
// drives write/issue traffic; expected read results are queued when each
// vector is driven and popped when the following read is compared.
// Hand-written sequences cover reset, same-cycle bypass and reset-with-traffic.
// -----------------------------------------------------------------------------
module tb_regfile_sb;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  regfile_sb_if #(.XLEN(32), .NREGS(32)) bus ();

  regfile_sb #(.XLEN(32), .NREGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        iss;
    logic [4:0]  ird;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    logic        e_b1;
    logic        e_b2;
    logic [31:0] e_vec;
  } vec_t;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic [31:0] vec;
  } exp_t;

  localparam int NV = 10;
  vec_t vecs [NV];
  exp_t sbq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.we0      = 1'b0;
    bus.we1      = 1'b0;
    bus.wa0      = 5'd0;
    bus.wa1      = 5'd0;
    bus.wd0      = 32'h0;
    bus.wd1      = 32'h0;
    bus.issue_en = 1'b0;
    bus.issue_rd = 5'd0;
  endtask

  initial begin
    exp_t e;
    checks = 0;
    errors = 0;

    //          we0  wa0    wd0           we1  wa1    wd1          iss  ird    ra1    ra2    e_d1          e_d2          b1    b2    vec
    vecs[0] = '{1'b1,5'd5, 32'hDEADBEEF,1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd5, 5'd0, 32'hDEADBEEF,32'h0,       1'b0,1'b0,32'h0};
    vecs[1] = '{1'b1,5'd0, 32'h12345678,1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd0, 5'd5, 32'h0,       32'hDEADBEEF,1'b0,1'b0,32'h0};
    vecs[2] = '{1'b1,5'd7, 32'h11,      1'b1,5'd7, 32'h22,      1'b0,5'd0, 5'd7, 5'd7, 32'h22,      32'h22,      1'b0,1'b0,32'h0};
    vecs[3] = '{1'b1,5'd3, 32'h33,      1'b1,5'd4, 32'h44,      1'b0,5'd0, 5'd3, 5'd4, 32'h33,      32'h44,      1'b0,1'b0,32'h0};
    vecs[4] = '{1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,       1'b1,5'd9, 5'd9, 5'd5, 32'h0,       32'hDEADBEEF,1'b1,1'b0,32'h00000200};
    vecs[5] = '{1'b0,5'd0, 32'h0,       1'b1,5'd9, 32'h99,      1'b1,5'd9, 5'd9, 5'd9, 32'h99,      32'h99,      1'b1,1'b1,32'h00000200};
    vecs[6] = '{1'b1,5'd9, 32'h9A,      1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd9, 5'd1, 32'h9A,      32'h0,       1'b0,1'b0,32'h0};
    vecs[7] = '{1'b1,5'd31,32'hFFFFFFFF,1'b0,5'd0, 32'h0,       1'b1,5'd31,5'd31,5'd30,32'hFFFFFFFF,32'h0,       1'b1,1'b0,32'h80000000};
    vecs[8] = '{1'b0,5'd0, 32'h0,       1'b1,5'd0, 32'hAAAA,    1'b1,5'd0, 5'd0, 5'd31,32'h0,       32'hFFFFFFFF,1'b0,1'b1,32'h80000000};
    vecs[9] = '{1'b0,5'd0, 32'h0,       1'b1,5'd31,32'h0,       1'b1,5'd2, 5'd31,5'd2, 32'h0,       32'h0,       1'b0,1'b1,32'h00000004};

    // Reset held for two edges with write and issue traffic present.
    reset = 1'b1;
    idle_inputs();
    bus.we0      = 1'b1;
    bus.wa0      = 5'd5;
    bus.wd0      = 32'h1;
    bus.issue_en = 1'b1;
    bus.issue_rd = 5'd9;
    bus.rs1_addr = 5'd0;
    bus.rs2_addr = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("reset busy_vec", bus.busy_vec, 32'h0);
    for (int a = 0; a < 32; a++) begin
      bus.rs1_addr = 5'(a);
      bus.rs2_addr = 5'(31 - a);
      #1;
      chk($sformatf("reset rs1_data[%0d]", a), bus.rs1_data, 32'h0);
      chk($sformatf("reset rs2_data[%0d]", 31 - a), bus.rs2_data, 32'h0);
      chk($sformatf("reset busy[%0d]", a), {31'h0, bus.rs1_busy | bus.rs2_busy}, 32'h0);
    end

    // Table-driven traffic: drive, edge, then read back with writes idle.
    for (int i = 0; i < NV; i++) begin
      bus.we0      = vecs[i].we0;
      bus.wa0      = vecs[i].wa0;
      bus.wd0      = vecs[i].wd0;
      bus.we1      = vecs[i].we1;
      bus.wa1      = vecs[i].wa1;
      bus.wd1      = vecs[i].wd1;
      bus.issue_en = vecs[i].iss;
      bus.issue_rd = vecs[i].ird;
      sbq.push_back('{vecs[i].e_d1, vecs[i].e_d2, vecs[i].e_b1, vecs[i].e_b2, vecs[i].e_vec});
      @(posedge clk);
      #1;
      idle_inputs();
      bus.rs1_addr = vecs[i].ra1;
      bus.rs2_addr = vecs[i].ra2;
      #1;
      e = sbq.pop_front();
      chk($sformatf("v%0d rs1_data", i), bus.rs1_data, e.d1);
      chk($sformatf("v%0d rs2_data", i), bus.rs2_data, e.d2);
      chk($sformatf("v%0d rs1_busy", i), {31'h0, bus.rs1_busy}, {31'h0, e.b1});
      chk($sformatf("v%0d rs2_busy", i), {31'h0, bus.rs2_busy}, {31'h0, e.b2});
      chk($sformatf("v%0d busy_vec", i), bus.busy_vec, e.vec);
    end

    // Same-cycle read of a register being written, with its busy bit set.
    // State here: r3=0x33, r4=0x44, busy_vec=0x4.
    bus.issue_en = 1'b1;
    bus.issue_rd = 5'd3;
    @(posedge clk);
    #1;
    idle_inputs();
    bus.we0      = 1'b1;
    bus.wa0      = 5'd3;
    bus.wd0      = 32'hA5;
    bus.we1      = 1'b1;
    bus.wa1      = 5'd0;
    bus.wd1      = 32'h77;
    bus.rs1_addr = 5'd0;
    bus.rs2_addr = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass rs2_data", bus.rs2_data, 32'hA5);
    chk("bypass rs2_busy", {31'h0, bus.rs2_busy}, 32'h0);
`else
    chk("nobypass rs2_data", bus.rs2_data, 32'h33);
    chk("nobypass rs2_busy", {31'h0, bus.rs2_busy}, 32'h1);
`endif
    chk("bypass addr0 rs1_data", bus.rs1_data, 32'h0);
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    chk("after write rs2_data", bus.rs2_data, 32'hA5);
    chk("after write rs2_busy", {31'h0, bus.rs2_busy}, 32'h0);
    chk("after write busy_vec", bus.busy_vec, 32'h4);

    // Both ports hit r4 while it is being read: port 1 data must win.
    bus.we0      = 1'b1;
    bus.wa0      = 5'd4;
    bus.wd0      = 32'h1;
    bus.we1      = 1'b1;
    bus.wa1      = 5'd4;
    bus.wd1      = 32'h2;
    bus.rs1_addr = 5'd4;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass prio rs1_data", bus.rs1_data, 32'h2);
`else
    chk("nobypass prio rs1_data", bus.rs1_data, 32'h44);
`endif
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    chk("prio stored rs1_data", bus.rs1_data, 32'h2);

    // Reset with write and issue traffic in the same cycle.
    reset        = 1'b1;
    bus.we0      = 1'b1;
    bus.wa0      = 5'd6;
    bus.wd0      = 32'h66;
    bus.issue_en = 1'b1;
    bus.issue_rd = 5'd6;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd6;
    #1;
    chk("rst traffic busy_vec", bus.busy_vec, 32'h0);
    chk("rst traffic r5", bus.rs1_data, 32'h0);
    chk("rst traffic r6", bus.rs2_data, 32'h0);
    chk("rst traffic busy6", {31'h0, bus.rs2_busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
